waveform_painter: RTL

- Display-side stage that takes the place of the checkerboard painter downstream of the VGA timer.
- Buffers one screen-width of 8-bit audio samples and renders them as a scrolling-free oscilloscope trace, with a horizontal centre axis.
- Samples arrive from the audio path over a valid/ready handshake.
- Pixel coordinates and the active flag come from the VGA timer; the block drives the 3/3/2 RGB outputs.

---
 rtl/waveform_painter.sv | 96 +++++++++
 1 files changed

// File: rtl/waveform_painter.sv
// Oscilloscope-style painter: buffers one line of audio samples in a ping-pong
// pair of banks and draws them as a trace over a horizontal centre axis.
module waveform_painter #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int AXIS_ROW     = 240,
  parameter int TRACE_OFFSET = 367
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       frame_sync,
  input  logic [9:0] hPix,
  input  logic [8:0] vPix,
  input  logic       isActive,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  localparam int AW = $clog2(H_RES);
  localparam int IW = $clog2(H_RES + 1);

  logic [7:0]    bank0 [H_RES];
  logic [7:0]    bank1 [H_RES];
  logic [IW-1:0] wr_idx;
  logic          bank_sel;
  logic          disp_valid;
  logic          full;
  logic          wr_en;
  logic          pix_in_range;

  logic [7:0]    rd_sample;
  logic [8:0]    vpix_d;
  logic          act_d;
  logic [9:0]    trace_row;

  assign full         = (wr_idx == IW'(H_RES));
  assign sample_ready = !full && !reset;
  assign wr_en        = sample_valid && sample_ready;
  assign pix_in_range = (hPix < 10'(H_RES)) && (vPix < 9'(V_RES));
  assign trace_row    = 10'(TRACE_OFFSET) - {2'b00, rd_sample};

  // bank_sel names the bank being written; the other one is on screen
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_sel) bank1[AW'(wr_idx)] <= sample_in;
      else          bank0[AW'(wr_idx)] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_in_range) begin
      rd_sample <= bank_sel ? bank0[AW'(hPix)] : bank1[AW'(hPix)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx     <= '0;
      bank_sel   <= 1'b0;
      disp_valid <= 1'b0;
      vpix_d     <= '0;
      act_d      <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      // a swap only happens when already full, so it never coincides with a write
      if (frame_sync && full) begin
        bank_sel   <= ~bank_sel;
        wr_idx     <= '0;
        disp_valid <= 1'b1;
      end else if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
      end

      vpix_d <= vPix;
      act_d  <= isActive && pix_in_range;

      red   <= '0;
      green <= '0;
      blue  <= '0;
      if (act_d) begin
        if (disp_valid && ({1'b0, vpix_d} == trace_row)) begin
          green <= 3'b111;
        end else if (vpix_d == 9'(AXIS_ROW)) begin
          blue <= 2'b10;
        end
      end
    end
  end

endmodule
